state_timer: RTL and testbench
==============================

// Module: state_timer
// PURPOSE
//   Dwell timer for the train controller FSM, downstream of the duration selector.
//   Loads the per-state duration (tload) each time present_state changes and counts it
//   down in ticks of TICK_DIV clocks. Pulses expired when the count reaches zero.
//   expired is the FSM's time-based transition condition.
// PARAMETERS
//   WIDTH     19          width of tload / remaining (duration in ticks)
//   STATE_W   4           width of present_state
//   TICK_DIV  50_000_000  clk cycles per tick (>=1); prescaler width = $clog2(TICK_DIV), min 1
// PORTS
//   clk            in   1        system clock, all logic on rising edge
//   rst_n          in   1        asynchronous reset, active low
//   present_state  in   STATE_W  current controller state
//   tload          in   WIDTH    selected duration; registered upstream, valid 1 clk after state change
//   hold           in   1        1 = freeze prescaler and count (emergency stop)
//   remaining      out  WIDTH    current count value
//   running        out  1        1 while in RUN
//   done           out  1        1 while in DONE (count exhausted, no new state yet)
//   expired        out  1        single-cycle pulse on entry to DONE
// BEHAVIOUR
//   Reset (async, rst_n=0), effective immediately without a clock edge:
//     - FSM=WAIT; remaining=0; prescaler=0; prev_state=0.
//     - running=0; done=0; expired=0.
//   Change detect: chg = (present_state != prev_state). prev_state <= present_state every clk.
//   FSM (registered; all transitions on rising clk):
//     WAIT: unconditional -> ARM. Gives upstream tload one edge to become valid after reset.
//     ARM : remaining<=tload, prescaler<=0. tload==0 -> DONE (expired=1 next cycle), else -> RUN.
//     RUN : if !hold, prescaler++. At prescaler==TICK_DIV-1:
//             - prescaler<=0, remaining--.
//             - remaining==1 at that tick -> remaining=0, -> DONE, expired=1 for 1 cycle.
//           hold=1: prescaler and remaining frozen; hold does not block chg.
//     DONE: remaining=0, done=1; stays until chg.
//   chg in any of ARM/RUN/DONE -> ARM (restart). Priority over tick/expiry in the same cycle:
//     no expired pulse, no decrement. chg in WAIT is ignored (WAIT->ARM anyway).
//   Timing (hold=0):
//     - chg sampled at edge N -> ARM; edge N+1 loads tload.
//     - remaining decrements every TICK_DIV clks after the load edge.
//     - expired high in the cycle after edge N+1+tload*TICK_DIV.
//     - hold extends this by exactly the number of held cycles.
//   Outputs are registered/decoded from state: running=(st==RUN), done=(st==DONE);
//     expired is a registered pulse, never high 2 consecutive cycles.
//   Arithmetic: remaining never underflows (no decrement at 0); prescaler wraps only at TICK_DIV-1.
//   TICK_DIV=1: decrement every enabled clk.
//   tload change during RUN is ignored; tload is sampled only in ARM.
// TESTING (TICK_DIV=4, constant present_state unless noted)
//   1 Release reset with tload=3 -> WAIT,ARM,RUN; remaining 3,2,1,0, each value held 4 clks;
//     expired 1-cycle pulse 12 clks after load edge; done=1 after.
//   2 tload=0 -> ARM->DONE; expired pulse the cycle after the load edge; running never 1.
//   3 tload=2, hold=1 for 10 clks mid-RUN -> remaining frozen during hold;
//     expired exactly 10 clks later than test 1 timing.
//   4 present_state changes on the same edge as the final tick -> no expired;
//     re-arm; new tload=5 loaded next edge.
//   5 In DONE, present_state 0000->0011 with tload=1 -> done drops; expired 4 clks after load edge.
//   6 rst_n low asynchronously mid-RUN (between edges) -> remaining=0, running=0 before next edge;
//     restarts via WAIT.

Source files
------------

// File: rtl/state_timer.sv
// Dwell timer for the train controller: reloads the per-state duration whenever
// present_state changes, counts it down in prescaled ticks and pulses expired at zero.
module state_timer #(
    parameter int WIDTH    = 19,
    parameter int STATE_W  = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] present_state,
    input  logic [WIDTH-1:0]   tload,
    input  logic               hold,
    output logic [WIDTH-1:0]   remaining,
    output logic               running,
    output logic               done,
    output logic               expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   remaining_reg, remaining_next;
    logic [PW-1:0]      prescaler_reg, prescaler_next;
    logic [STATE_W-1:0] prev_state_reg;
    logic               expired_reg, expired_next;
    logic               chg;

    assign chg = (present_state != prev_state_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_WAIT;
            remaining_reg  <= '0;
            prescaler_reg  <= '0;
            prev_state_reg <= '0;
            expired_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            prescaler_reg  <= prescaler_next;
            prev_state_reg <= present_state;
            expired_reg    <= expired_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        prescaler_next = prescaler_reg;
        expired_next   = 1'b0;
        case (state_reg)
            // One edge of slack so the upstream duration register settles after reset.
            ST_WAIT: state_next = ST_ARM;
            ST_ARM: begin
                remaining_next = tload;
                prescaler_next = '0;
                if (chg) begin
                    state_next = ST_ARM;
                end else if (tload == '0) begin
                    state_next   = ST_DONE;
                    expired_next = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A state change wins over a coinciding tick: restart without pulsing.
                if (chg) begin
                    state_next = ST_ARM;
                end else if (!hold) begin
                    if (prescaler_reg == PRE_MAX) begin
                        prescaler_next = '0;
                        if (remaining_reg <= WIDTH'(1)) begin
                            remaining_next = '0;
                            state_next     = ST_DONE;
                            expired_next   = 1'b1;
                        end else begin
                            remaining_next = remaining_reg - WIDTH'(1);
                        end
                    end else begin
                        prescaler_next = prescaler_reg + PW'(1);
                    end
                end
            end
            ST_DONE: begin
                remaining_next = '0;
                if (chg) state_next = ST_ARM;
            end
            default: state_next = ST_WAIT;
        endcase
    end

    assign remaining = remaining_reg;
    assign running   = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);
    assign expired   = expired_reg;

endmodule

// File: tb/tb_state_timer.sv
// Randomised and directed bench for state_timer with TICK_DIV=4, compared each cycle
// against an elapsed-time model of the dwell timer.
module tb_state_timer;

    localparam int WIDTH   = 19;
    localparam int STATE_W = 4;
    localparam int TD      = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [STATE_W-1:0] present_state = '0;
    logic [WIDTH-1:0]   tload = '0;
    logic               hold = 1'b0;
    logic [WIDTH-1:0]   remaining;
    logic               running;
    logic               done;
    logic               expired;

    int checks = 0;
    int errors = 0;

    state_timer #(.WIDTH(WIDTH), .STATE_W(STATE_W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .present_state(present_state), .tload(tload),
        .hold(hold), .remaining(remaining), .running(running), .done(done),
        .expired(expired)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 idle-after-reset, 1 loading, 2 counting, 3 finished.
    // Remaining is derived from the number of unheld counting clocks since the load.
    int                 m_phase;
    int                 m_load;
    int                 m_en;
    logic [WIDTH-1:0]   m_rem;
    logic               m_exp;
    logic [STATE_W-1:0] m_prev;

    task automatic model_reset();
        m_phase = 0; m_load = 0; m_en = 0; m_rem = '0; m_exp = 1'b0; m_prev = '0;
    endtask

    task automatic model_update();
        logic c;
        c      = (present_state != m_prev);
        m_prev = present_state;
        m_exp  = 1'b0;
        case (m_phase)
            0: m_phase = 1;
            1: begin
                m_load = int'(tload);
                m_en   = 0;
                m_rem  = tload;
                if (c) m_phase = 1;
                else if (m_load == 0) begin m_phase = 3; m_exp = 1'b1; end
                else m_phase = 2;
            end
            2: begin
                if (c) m_phase = 1;
                else if (!hold) begin
                    m_en  = m_en + 1;
                    m_rem = WIDTH'(m_load - m_en / TD);
                    if (m_en == m_load * TD) begin m_phase = 3; m_exp = 1'b1; end
                end
            end
            default: begin
                m_rem = '0;
                if (c) m_phase = 1;
            end
        endcase
    endtask

    // One clock: model steps on the edge, outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [WIDTH+2:0] want_vec();
        return {m_rem, (m_phase == 2), (m_phase == 3), m_exp};
    endfunction

    task automatic test_reset();
        tload = 19'd3; present_state = '0; hold = 1'b0; rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({remaining, running, done, expired} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {remaining, running, done, expired});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int exp_at = -1;
        int nexp = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({remaining, running, done, expired} !== want_vec()) begin
                errors++;
                $display("FAIL basic_cycle%0d: got %h want %h", i,
                         {remaining, running, done, expired}, want_vec());
            end
            if (expired) begin nexp++; if (exp_at < 0) exp_at = i; end
        end
        checks++;
        if (exp_at !== 14 || nexp !== 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_expiry: got edge %0d count %0d done %b want 14 1 1",
                     exp_at, nexp, done);
        end
    endtask

    task automatic test_zero();
        int exp_at = -1;
        logic ran = 1'b0;
        present_state = 4'd1; tload = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({remaining, running, done, expired} !== want_vec()) begin
                errors++;
                $display("FAIL zero_cycle%0d: got %h want %h", i,
                         {remaining, running, done, expired}, want_vec());
            end
            if (expired && exp_at < 0) exp_at = i;
            ran = ran | running;
        end
        checks++;
        if (exp_at !== 2 || ran !== 1'b0) begin
            errors++;
            $display("FAIL zero_expiry: got edge %0d running %b want 2 0", exp_at, ran);
        end
    endtask

    task automatic test_hold();
        int exp_at = -1;
        logic [WIDTH-1:0] frozen = '0;
        present_state = 4'd2; tload = 19'd2;
        for (int i = 1; i <= 24; i++) begin
            hold = (i >= 5 && i < 15);
            if (i == 5) frozen = remaining;
            tick();
            checks++;
            if ({remaining, running, done, expired} !== want_vec()) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h want %h", i,
                         {remaining, running, done, expired}, want_vec());
            end
            if (i >= 5 && i < 15) begin
                checks++;
                if (remaining !== frozen) begin
                    errors++;
                    $display("FAIL hold_frozen%0d: got %0d want %0d", i, remaining, frozen);
                end
            end
            if (expired && exp_at < 0) exp_at = i;
        end
        hold = 1'b0;
        checks++;
        if (exp_at !== 20) begin
            errors++;
            $display("FAIL hold_expiry: got edge %0d want 20", exp_at);
        end
    endtask

    task automatic test_back_to_back();
        int nexp = 0;
        present_state = 4'd5; tload = 19'd2;
        for (int i = 1; i <= 9; i++) tick();
        present_state = 4'd0; tload = 19'd5;
        tick();
        checks++;
        if (expired !== 1'b0 || running !== 1'b0 || remaining !== 19'd1) begin
            errors++;
            $display("FAIL b2b_preempt: got exp %b run %b rem %0d want 0 0 1",
                     expired, running, remaining);
        end
        tick();
        checks++;
        if (remaining !== 19'd5 || running !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reload: got rem %0d run %b want 5 1", remaining, running);
        end
        for (int i = 1; i <= 22; i++) begin
            tick();
            checks++;
            if ({remaining, running, done, expired} !== want_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h want %h", i,
                         {remaining, running, done, expired}, want_vec());
            end
            if (expired) nexp++;
        end
        checks++;
        if (nexp !== 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_finish: got count %0d done %b want 1 1", nexp, done);
        end
    endtask

    task automatic test_done_restart();
        int exp_at = -1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_done: got %b want 1", done);
        end
        present_state = 4'd3; tload = 19'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_done_drop: got %b want 0", done);
                end
            end
            if (expired && exp_at < 0) exp_at = i;
        end
        checks++;
        if (exp_at !== 6) begin
            errors++;
            $display("FAIL restart_expiry: got edge %0d want 6", exp_at);
        end
    endtask

    task automatic test_async_reset();
        present_state = 4'd4; tload = 19'd7;
        for (int i = 1; i <= 6; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({remaining, running, done, expired} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", {remaining, running, done, expired});
        end
        model_reset();
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (running !== 1'b0 || remaining !== '0) begin
            errors++;
            $display("FAIL async_wait: got run %b rem %0d want 0 0", running, remaining);
        end
        tick();
        tick();
        checks++;
        if (running !== 1'b1 || remaining !== 19'd7) begin
            errors++;
            $display("FAIL async_rerun: got run %b rem %0d want 1 7", running, remaining);
        end
    endtask

    task automatic test_random();
        logic last_exp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) present_state = STATE_W'($urandom_range(0, 15));
            tload = WIDTH'($urandom_range(0, 3));
            hold  = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if ({remaining, running, done, expired} !== want_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i,
                         {remaining, running, done, expired}, want_vec());
            end
            checks++;
            if (expired && last_exp) begin
                errors++;
                $display("FAIL random_double_pulse%0d: got 2 consecutive want 1", i);
            end
            last_exp = expired;
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_hold();
        test_back_to_back();
        test_done_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
